// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
// State encodings match the core's existing arbiter state values.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbBusyIf = 2'd1,
    ArbBusyDm = 2'd2
  } arbStateT;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// Data wins unless fetch is waiting and the data streak is exhausted.
module mem_arb_pick (
  input  logic if_req,
  input  logic dm_req,
  input  logic mask_if,
  input  logic mask_dm,
  input  logic streak_full,
  output logic grant_if,
  output logic grant_dm
);

  logic ifLive;
  logic dmLive;

  always_comb begin
    ifLive   = if_req & ~mask_if;
    dmLive   = dm_req & ~mask_dm;
    grant_if = ifLive & (~dmLive | streak_full);
    grant_dm = dmLive & ~grant_if;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and
// data load/store; routes read data back and stalls the PC while a fetch is pending.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STREAK_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              pc_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int unsigned StreakW  = $clog2(STREAK_MAX + 1);
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYC + 1);

  arbStateT              stateQ, stateD;
  logic                  memReqQ, memReqD;
  logic                  memWeQ, memWeD;
  logic [ADDR_W-1:0]     memAddrQ, memAddrD;
  logic [DATA_W-1:0]     memWdataQ, memWdataD;
  logic                  ifRvalidQ, ifRvalidD;
  logic                  dmRvalidQ, dmRvalidD;
  logic [DATA_W-1:0]     ifRdataQ, ifRdataD;
  logic [DATA_W-1:0]     dmRdataQ, dmRdataD;
  logic                  errQ, errD;
  logic [StreakW-1:0]    streakQ, streakD;
  logic [TimeoutW-1:0]   timeoutQ, timeoutD;

  logic busy, ownerIf, ownerDm, done, timedOut, arbNow;
  logic maskIf, maskDm, streakFull, pickIf, pickDm;

  assign busy       = (stateQ != ArbIdle);
  assign ownerIf    = (stateQ == ArbBusyIf);
  assign ownerDm    = (stateQ == ArbBusyDm);
  assign done       = busy & mem_ready;
  assign timedOut   = busy & ~mem_ready & (timeoutQ == TimeoutW'(TIMEOUT_CYC - 1));
  assign arbNow     = ~busy | done;
  assign streakFull = (streakQ == StreakW'(STREAK_MAX));

  // A requester still holds its req while completing and during its rvalid cycle;
  // that level belongs to the finished access, not a new one.
  assign maskIf = (done & ownerIf) | ifRvalidQ;
  assign maskDm = (done & ownerDm) | dmRvalidQ;

  mem_arb_pick uPick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .mask_if    (maskIf),
    .mask_dm    (maskDm),
    .streak_full(streakFull),
    .grant_if   (pickIf),
    .grant_dm   (pickDm)
  );

  always_comb begin
    stateD    = stateQ;
    memReqD   = memReqQ;
    memWeD    = memWeQ;
    memAddrD  = memAddrQ;
    memWdataD = memWdataQ;
    ifRvalidD = 1'b0;
    dmRvalidD = 1'b0;
    ifRdataD  = ifRdataQ;
    dmRdataD  = dmRdataQ;
    errD      = errQ;
    streakD   = streakQ;
    timeoutD  = timeoutQ;

    if (timedOut) begin
      errD    = 1'b1;
      stateD  = ArbIdle;
      memReqD = 1'b0;
      memWeD  = 1'b0;
      if (ownerIf) begin
        ifRvalidD = 1'b1;
        ifRdataD  = '0;
      end else begin
        dmRvalidD = 1'b1;
        dmRdataD  = '0;
      end
    end else if (arbNow) begin
      if (done) begin
        if (ownerIf) begin
          ifRvalidD = 1'b1;
          ifRdataD  = mem_rdata;
        end else begin
          dmRvalidD = 1'b1;
          if (!memWeQ) dmRdataD = mem_rdata;
        end
      end
      if (pickIf) begin
        stateD   = ArbBusyIf;
        memReqD  = 1'b1;
        memWeD   = 1'b0;
        memAddrD = if_addr;
        streakD  = '0;
        timeoutD = '0;
      end else if (pickDm) begin
        stateD    = ArbBusyDm;
        memReqD   = 1'b1;
        memWeD    = dm_we;
        memAddrD  = dm_addr;
        memWdataD = dm_wdata;
        timeoutD  = '0;
        if (!if_req) streakD = '0;
        else if (!streakFull) streakD = streakQ + StreakW'(1);
      end else begin
        stateD  = ArbIdle;
        memReqD = 1'b0;
        memWeD  = 1'b0;
      end
    end else begin
      timeoutD = timeoutQ + TimeoutW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateQ    <= ArbIdle;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      ifRvalidQ <= 1'b0;
      dmRvalidQ <= 1'b0;
      ifRdataQ  <= '0;
      dmRdataQ  <= '0;
      errQ      <= 1'b0;
      streakQ   <= '0;
      timeoutQ  <= '0;
    end else begin
      stateQ    <= stateD;
      memReqQ   <= memReqD;
      memWeQ    <= memWeD;
      memAddrQ  <= memAddrD;
      memWdataQ <= memWdataD;
      ifRvalidQ <= ifRvalidD;
      dmRvalidQ <= dmRvalidD;
      ifRdataQ  <= ifRdataD;
      dmRdataQ  <= dmRdataD;
      errQ      <= errD;
      streakQ   <= streakD;
      timeoutQ  <= timeoutD;
    end
  end

  assign mem_req   = memReqQ;
  assign mem_we    = memWeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;
  assign if_rvalid = ifRvalidQ;
  assign dm_rvalid = dmRvalidQ;
  assign if_rdata  = ifRdataQ;
  assign dm_rdata  = dmRdataQ;
  assign err       = errQ;
  assign pc_stall  = if_req & ~ifRvalidQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transaction table, multi-cycle corner sequences,
// then randomized traffic against a behavioural reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;
  localparam int unsigned TMO  = 255;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic          if_rvalid, dm_rvalid, pc_stall, mem_req, mem_we, err;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .pc_stall(pc_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  typedef struct {
    logic          isDm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            waits;
    logic [DW-1:0] expRdata;
  } vecT;

  vecT tbl[5];
  int  checks = 0;
  int  failures = 0;

  // Reference model state: who owns the memory and what each output should show.
  int            mOwner, mWait, mStreak;
  logic          mReq, mWe, mIfV, mDmV, mErr;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata, mIfD, mDmD;
  logic          ifFree, dmFree, ifWasRv, dmWasRv, zw;
  int            ifDone3, dmDone3, cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic runTxn(input vecT v, input int idx);
    if (v.isDm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    mem_ready = 1'b0;
    tick();
    chk($sformatf("txn%0d mem_req", idx), mem_req, 1);
    chk($sformatf("txn%0d mem_addr", idx), mem_addr, v.addr);
    chk($sformatf("txn%0d mem_we", idx), mem_we, v.we);
    if (v.we) chk($sformatf("txn%0d mem_wdata", idx), mem_wdata, v.wdata);
    if (!v.isDm) chk($sformatf("txn%0d pc_stall busy", idx), pc_stall, 1);
    for (int i = 0; i < v.waits; i++) tick();
    mem_ready = 1'b1; mem_rdata = v.rdata;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h5555_aaaa;
    if (v.isDm) begin
      chk($sformatf("txn%0d dm_rvalid", idx), dm_rvalid, 1);
      chk($sformatf("txn%0d if_rvalid", idx), if_rvalid, 0);
      chk($sformatf("txn%0d dm_rdata", idx), dm_rdata, v.expRdata);
    end else begin
      chk($sformatf("txn%0d if_rvalid", idx), if_rvalid, 1);
      chk($sformatf("txn%0d dm_rvalid", idx), dm_rvalid, 0);
      chk($sformatf("txn%0d if_rdata", idx), if_rdata, v.expRdata);
      chk($sformatf("txn%0d pc_stall done", idx), pc_stall, 0);
    end
    chk($sformatf("txn%0d mem_req idle", idx), mem_req, 0);
    tick();
    chk($sformatf("txn%0d rvalid pulse", idx), {if_rvalid, dm_rvalid}, 0);
    chk($sformatf("txn%0d no regrant", idx), mem_req, 0);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    tick();
  endtask

  task automatic modelStep();
    logic done, expire, ifCand, dmCand;
    done   = (mOwner != 0) && mem_ready;
    expire = (mOwner != 0) && !mem_ready && (mWait + 1 == int'(TMO));
    ifCand = if_req && !mIfV && !(done && mOwner == 1);
    dmCand = dm_req && !mDmV && !(done && mOwner == 2);
    mIfV = 1'b0;
    mDmV = 1'b0;
    if (expire) begin
      mErr = 1'b1;
      if (mOwner == 1) begin mIfV = 1'b1; mIfD = '0; end
      else begin mDmV = 1'b1; mDmD = '0; end
      mOwner = 0; mReq = 1'b0; mWe = 1'b0;
    end else if (mOwner == 0 || done) begin
      if (done) begin
        if (mOwner == 1) begin mIfV = 1'b1; mIfD = mem_rdata; end
        else begin mDmV = 1'b1; if (!mWe) mDmD = mem_rdata; end
      end
      mWait = 0;
      if (ifCand && (!dmCand || mStreak == int'(SMAX))) begin
        mOwner = 1; mReq = 1'b1; mWe = 1'b0; mAddr = if_addr; mStreak = 0;
      end else if (dmCand) begin
        mOwner = 2; mReq = 1'b1; mWe = dm_we; mAddr = dm_addr; mWdata = dm_wdata;
        mStreak = !if_req ? 0 : (mStreak < int'(SMAX) ? mStreak + 1 : mStreak);
      end else begin
        mOwner = 0; mReq = 1'b0; mWe = 1'b0;
      end
    end else begin
      mWait++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h2402_0001, 0, 32'h2402_0001};
    tbl[1] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'h1234_5678, 2, 32'h1234_5678};
    tbl[2] = '{1'b1, 1'b1, 32'h1001_0004, 32'hcafe_f00d, 32'hdead_beef, 1, 32'h1234_5678};
    tbl[3] = '{1'b0, 1'b0, 32'h0040_0004, 32'h0, 32'h8c08_0000, 3, 32'h8c08_0000};
    tbl[4] = '{1'b1, 1'b0, 32'h1001_0008, 32'h0, 32'h0bad_f00d, 0, 32'h0bad_f00d};

    // Reset state
    tick(); tick();
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset rvalids", {if_rvalid, dm_rvalid}, 0);
    chk("reset err", err, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset rdata", if_rdata | dm_rdata, 0);
    reset_n = 1'b1;
    tick();

    foreach (tbl[i]) runTxn(tbl[i], i);

    // Simultaneous requests: data first, fetch back-to-back
    if_req = 1'b1; if_addr = 32'h0040_0008;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0000;
    tick();
    chk("both first addr", mem_addr, 32'h1001_0000);
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    chk("both dm_rvalid", dm_rvalid, 1);
    chk("both dm_rdata", dm_rdata, 32'h1111_2222);
    chk("both if_rvalid early", if_rvalid, 0);
    chk("both mem_req held", mem_req, 1);
    chk("both second addr", mem_addr, 32'h0040_0008);
    mem_rdata = 32'h3333_4444;
    tick();
    mem_ready = 1'b0;
    dm_req = 1'b0;
    chk("both if_rvalid", if_rvalid, 1);
    chk("both if_rdata", if_rdata, 32'h3333_4444);
    chk("both dm_rvalid off", dm_rvalid, 0);
    chk("both mem_req off", mem_req, 0);
    tick();
    if_req = 1'b0;
    tick();

    // Timeout with mem_ready stuck low
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0010;
    tick();
    cnt = 0;
    for (int i = 0; i < 300 && mem_req; i++) begin
      cnt++;
      tick();
    end
    chk("timeout busy cycles", cnt, TMO);
    chk("timeout dm_rvalid", dm_rvalid, 1);
    chk("timeout dm_rdata", dm_rdata, 0);
    chk("timeout err", err, 1);
    chk("timeout mem_req", mem_req, 0);
    tick();
    dm_req = 1'b0;
    chk("timeout no regrant", mem_req, 0);
    tick();
    runTxn(tbl[0], 10);
    chk("err sticky", err, 1);

    // Asynchronous reset in the middle of a fetch
    if_req = 1'b1; if_addr = 32'h0040_0100;
    tick();
    chk("rst busy mem_req", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst async mem_req", mem_req, 0);
    chk("rst async err", err, 0);
    chk("rst async mem_addr", mem_addr, 0);
    chk("rst async rdata", if_rdata | dm_rdata, 0);
    #2 reset_n = 1'b1;
    tick();
    chk("rst regrant mem_req", mem_req, 1);
    chk("rst regrant addr", mem_addr, 32'h0040_0100);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ready = 1'b0;
    chk("rst regrant rvalid", if_rvalid, 1);
    chk("rst regrant rdata", if_rdata, 32'h0000_0013);
    tick();
    if_req = 1'b0;
    tick();

    // Randomized traffic against the reference model
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mOwner = 0; mWait = 0; mStreak = 0;
    mReq = 0; mWe = 0; mIfV = 0; mDmV = 0; mErr = 0;
    mAddr = '0; mWdata = '0; mIfD = '0; mDmD = '0;
    ifFree = 1; dmFree = 1; ifWasRv = 0; dmWasRv = 0;
    ifDone3 = 0; dmDone3 = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      zw = (cyc < 300);
      tick();
      chk("rnd mem_req", mem_req, mReq);
      chk("rnd mem_we", mem_we, mWe);
      if (mReq) chk("rnd mem_addr", mem_addr, mAddr);
      if (mWe) chk("rnd mem_wdata", mem_wdata, mWdata);
      chk("rnd if_rvalid", if_rvalid, mIfV);
      chk("rnd dm_rvalid", dm_rvalid, mDmV);
      chk("rnd if_rdata", if_rdata, mIfD);
      chk("rnd dm_rdata", dm_rdata, mDmD);
      chk("rnd err", err, mErr);
      if (zw && mIfV) ifDone3++;
      if (zw && mDmV) dmDone3++;
      if (ifWasRv) ifFree = 1;
      if (dmWasRv) dmFree = 1;
      ifWasRv = mIfV;
      dmWasRv = mDmV;
      if (ifFree) begin
        if (zw || $urandom_range(0, 3) != 0) begin
          if_req = 1'b1; if_addr = $urandom; ifFree = 0;
        end else if_req = 1'b0;
      end
      if (dmFree) begin
        if (zw || $urandom_range(0, 2) != 0) begin
          dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
          dm_addr = $urandom; dm_wdata = $urandom; dmFree = 0;
        end else begin
          dm_req = 1'b0; dm_we = 1'b0;
        end
      end
      mem_ready = mReq && (zw || $urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      #1;
      chk("rnd pc_stall", pc_stall, if_req & ~mIfV);
      modelStep();
    end
    chk("saturated fetch progress", ifDone3 > 10, 1);
    chk("saturated data progress", dmDone3 > 10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
